// File: rtl/sha256_msg_schedule_if.sv
// Word stream into the SHA-256 message schedule.
// Source holds msg_word until msg_valid & msg_ready at a rising edge.
interface sha256_msg_schedule_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_word;

    modport master (
        output msg_valid,
        output msg_word,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_word,
        output msg_ready
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 chunk loader and 64-round message schedule / K[t] source.
// Optional SHA256_BSWAP_IN_EN byte-reverses each accepted word.
module sha256_msg_schedule (
    input  logic                       clk,
    input  logic                       rst_n,
    sha256_msg_schedule_if.slave       msg,
    output logic [31:0]                w_out,
    output logic [31:0]                k_out,
    output logic                       proc_start,
    output logic                       update_hash,
    output logic                       busy,
    output logic                       chunk_done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state;
    state_t      state_nx;
    logic [5:0]  cnt;
    logic [31:0] win [16];
    logic        done_q;
    logic        xfer;
    logic [31:0] din;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign xfer = msg.msg_valid && (state == LOAD);

`ifdef SHA256_BSWAP_IN_EN
    assign din = {msg.msg_word[7:0], msg.msg_word[15:8],
                  msg.msg_word[23:16], msg.msg_word[31:24]};
`else
    assign din = msg.msg_word;
`endif

    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (xfer && cnt == 6'd15) state_nx = RUN;
            RUN:     if (cnt == 6'd63) state_nx = FINAL;
            FINAL:   state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            cnt    <= 6'd0;
            done_q <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= 32'd0;
        end else begin
            state  <= state_nx;
            done_q <= (state == FINAL);
            unique case (state)
                LOAD: begin
                    if (xfer) begin
                        win[cnt[3:0]] <= din;
                        cnt <= (cnt == 6'd15) ? 6'd0 : cnt + 6'd1;
                    end
                end
                RUN: begin
                    // shift continues past t=48 even though those words go unused
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= w_new;
                    cnt <= cnt + 6'd1;
                end
                default: cnt <= 6'd0;
            endcase
        end
    end

    assign msg.msg_ready = (state == LOAD);
    assign busy          = (state != LOAD);
    assign proc_start    = (state != LOAD);
    assign update_hash   = (state == FINAL);
    assign chunk_done    = done_q;
    assign w_out         = (state == RUN) ? win[0] : 32'd0;
    assign k_out         = (state == RUN) ? K[cnt] : 32'd0;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomised bench for sha256_msg_schedule against a FIPS 180-4 schedule model.
// Model: load 16 words, then rounds, final, done pulse.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] w_out, k_out;
    logic        proc_start, update_hash, busy, chunk_done;

    sha256_msg_schedule_if msg();

    sha256_msg_schedule dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg         (msg),
        .w_out       (w_out),
        .k_out       (k_out),
        .proc_start  (proc_start),
        .update_hash (update_hash),
        .busy        (busy),
        .chunk_done  (chunk_done)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // word as the source must present it to yield big-endian w
    function automatic logic [31:0] to_bus(input logic [31:0] w);
`ifdef SHA256_BSWAP_IN_EN
        return bswap(w);
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] from_bus(input logic [31:0] w);
`ifdef SHA256_BSWAP_IN_EN
        return bswap(w);
`else
        return w;
`endif
    endfunction

    typedef enum {M_LOAD, M_RUN, M_FINAL} mph_t;
    mph_t        ph;
    int          nw, rnd_t;
    bit          mdone;
    logic [31:0] mwords [16];
    logic [31:0] mw [64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = M_LOAD; nw = 0; rnd_t = 0; mdone = 0;
        end else begin
            case (ph)
                M_LOAD: begin
                    mdone = 0;
                    if (msg.msg_valid === 1'b1) begin
                        mwords[nw] = from_bus(msg.msg_word);
                        nw++;
                        if (nw == 16) begin
                            for (int t = 0; t < 16; t++) mw[t] = mwords[t];
                            for (int t = 16; t < 64; t++)
                                mw[t] = ss1(mw[t-2]) + mw[t-7] + ss0(mw[t-15]) + mw[t-16];
                            nw = 0; rnd_t = 0; ph = M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    if (rnd_t == 63) ph = M_FINAL;
                    else rnd_t++;
                end
                default: begin
                    ph = M_LOAD; mdone = 1;
                end
            endcase
        end
    end

    // {ready, busy, proc_start, update_hash, chunk_done, w, k}
    function automatic logic [68:0] exp_vec();
        case (ph)
            M_LOAD:  return {1'b1, 1'b0, 1'b0, 1'b0, mdone, 32'd0, 32'd0};
            M_RUN:   return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mw[rnd_t], ktab[rnd_t]};
            default: return {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
        endcase
    endfunction

    function automatic logic [68:0] act_vec();
        return {msg.msg_ready, busy, proc_start, update_hash, chunk_done, w_out, k_out};
    endfunction

    task automatic check_vec(input string name, input logic [68:0] act, input logic [68:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s t=%0t: got rdy/busy/ps/uh/done=%b w=%h k=%h, want %b w=%h k=%h",
                      name, $time, act[68:64], act[63:32], act[31:0],
                      exp[68:64], exp[63:32], exp[31:0]);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) check_vec("cycle", act_vec(), exp_vec());
    end

    task automatic send_word(input logic [31:0] w, input bit rnd);
        bit acc = 0;
        int guard = 0;
        msg.msg_word = w;
        while (!acc) begin
            msg.msg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = msg.msg_valid && msg.msg_ready;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) begin
                $display("FAIL send_word: no acceptance within 300 cycles");
                $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
                $fatal(1, "stalled");
            end
        end
    endtask

    task automatic send_rand_chunk(input bit rnd, input int nwords);
        for (int i = 0; i < nwords; i++) send_word($urandom, rnd);
    endtask

    logic [31:0] abc [16];
    int ps_n, uh_n, uh_at, dn;

    initial begin
        msg.msg_valid = 1'b0;
        msg.msg_word  = 32'd0;
        for (int i = 0; i < 16; i++) abc[i] = 32'd0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        cmp_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) send_word(to_bus(abc[i]), 1'b0);
        msg.msg_valid = 1'b0;
        check32("model_W16", mw[16], 32'h61626380);
        check32("model_W17", mw[17], 32'h000f0000);

        ps_n = 0; uh_n = 0; uh_at = 0; dn = 0;
        for (int c = 0; c < 100 && dn == 0; c++) begin
            @(negedge clk);
            if (proc_start) ps_n++;
            if (proc_start && ps_n == 1) begin
                check32("abc_w_t0", w_out, 32'h61626380);
                check32("abc_k_t0", k_out, 32'h428a2f98);
            end
            if (proc_start && ps_n == 18) check32("abc_w_t17", w_out, 32'h000f0000);
            if (proc_start && ps_n == 64) check32("abc_k_t63", k_out, 32'hc67178f2);
            if (update_hash) begin uh_n++; uh_at = ps_n; end
            if (chunk_done) dn = 1;
        end
        check32("ps_cycles", 32'(ps_n), 32'd65);
        check32("uh_cycles", 32'(uh_n), 32'd1);
        check32("uh_position", 32'(uh_at), 32'd65);
        check32("done_seen", 32'(dn), 32'd1);
        @(negedge clk);
        check32("done_one_pulse", {31'd0, chunk_done}, 32'd0);
        @(posedge clk);
        #1;

        for (int c = 0; c < 3; c++) send_rand_chunk(1'b1, 16);
        send_rand_chunk(1'b0, 16);
        send_rand_chunk(1'b1, 16);
        msg.msg_valid = 1'b0;
        repeat (80) @(posedge clk);
        #1;

        send_rand_chunk(1'b0, 16);
        msg.msg_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_vec("reset_at_once", act_vec(),
                     {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
        msg.msg_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        send_rand_chunk(1'b1, 15);
        msg.msg_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check32("no_start_after_15", {31'd0, proc_start}, 32'd0);
        @(posedge clk);
        #1;
        send_rand_chunk(1'b0, 1);
        msg.msg_valid = 1'b0;
        @(negedge clk);
        check32("start_after_16", {31'd0, proc_start}, 32'd1);
        repeat (75) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Chunk front-end for the SHA-256 compression datapath. Accepts one 512-bit chunk as sixteen 32-bit words over a valid/ready stream. Expands the words into the 64-entry message schedule and drives W[t], K[t] and the round control into the compression core, one round per clock. It is the producer side of the `w_in`/`k_in`/`proc_start`/`update_hash` interface, sitting between the PS-facing word buffer and the compressor.

## Interface
- No parameters.
- `clk` input 1: sole clock; all state on rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `msg_valid` input 1: `msg_word` valid this cycle.
- `msg_ready` output 1: block accepts a word; a transfer occurs when `msg_valid & msg_ready` at the rising edge.
- `msg_word` input 32: message word, chunk order W[0]..W[15].
- `w_out` output 32: W[t] for the current round; goes to the compressor `w_in`.
- `k_out` output 32: K[t] round constant; goes to the compressor `k_in`.
- `proc_start` output 1: compressor round enable.
- `update_hash` output 1: compressor hash-accumulate strobe.
- `busy` output 1: high in RUN and FINAL.
- `chunk_done` output 1: one-cycle pulse after the FINAL cycle.

## Operation
- States:
  - LOAD: `msg_ready`=1; word counter 0..15; each transfer writes window slot [cnt].
  - RUN: round counter t=0..63.
  - FINAL: one cycle.
- Transitions:
  - LOAD→RUN on the 16th transfer.
  - RUN→FINAL when t=63.
  - FINAL→LOAD unconditionally; the word counter clears.
- Schedule window is 16×32 registers; in RUN it holds W[t..t+15]. `w_out` = slot[0].
- Each RUN cycle the window shifts down one slot. Slot[15] loads s1(slot[14]) + slot[9] + s0(slot[1]) + slot[0], mod 2^32, where:
  - s0(x) = rotr7 ^ rotr18 ^ shr3
  - s1(x) = rotr17 ^ rotr19 ^ shr10
- For t≥48 the newly computed words are never consumed. The shift still occurs.
- `k_out` = internal 64×32 constant ROM [t] (FIPS 180-4 K table) during RUN.
- `proc_start` is 1 in RUN and FINAL, 0 otherwise.
- `update_hash` is 1 only in FINAL.
- In LOAD: `w_out`=0, `k_out`=0.
- In FINAL: `w_out` and `k_out` are don't-care and driven 0.
- Consecutive chunks accumulate in the compressor. A new message requires `rst_n` assertion; this block has no per-message clear.
- `msg_valid` while `msg_ready`=0 is ignored. The source holds the word until accepted.

## Timing
- Reset values:
  - state LOAD, counters 0, window 0.
  - `msg_ready`=1, `busy`=0, `proc_start`=0, `update_hash`=0, `chunk_done`=0, `w_out`=0, `k_out`=0.
- 16th transfer at edge N: cycle after N is RUN t=0, with `proc_start`=1, `w_out`=W[0], `k_out`=0x428a2f98.
- Round t is presented in cycle N+1+t. FINAL is cycle N+65.
- `chunk_done`=1 and `msg_ready`=1 in cycle N+66.
- Minimum chunk period is 81 cycles at full source rate.
- All outputs decode from registered state. There is no combinational path from `msg_valid` or `msg_word` to any output.
- Reset mid-chunk, in any state: immediate return to LOAD with reset values. A partially loaded chunk is discarded.

## Configuration
- `SHA256_BSWAP_IN_EN` defined: each accepted `msg_word` is byte-reversed before storage ({b0,b1,b2,b3}) to match little-endian PS writes. This mirrors the compressor's output swap.
- Not defined: words are stored as received, already big-endian.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN → all outputs return to reset values at once. After release, 16 new words are required before `proc_start` rises.
- "abc" chunk, macro off: words 0x61626380, 0×14, 0x00000018.
  - Rounds 0-15 echo the inputs.
  - W[16]=0x61626380, W[17]=0x000f0000.
  - `k_out` t=0 is 0x428a2f98; t=63 is 0xc67178f2.
- Control timing: check over the same chunk.
  - `proc_start` is high exactly 65 cycles.
  - `update_hash` is high only on the 65th cycle.
  - `chunk_done` pulses once, in the following cycle.
- With the compressor attached, "abc" → compressor `hash0`=0xbf1678ba and `hash7`=0xad1500f2 (digest ba7816bf…f20015ad, byte-swapped).
- Macro on: word 0 sent as 0x80636261 → `w_out` at t=0 is 0x61626380. Digest is identical to the macro-off run.
- Backpressure: toggle `msg_valid` randomly, and hold `msg_valid`=1 during RUN → no extra words are captured. The next chunk starts loading only in the `chunk_done` cycle.
